// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default widths, occupancy
// type, the bubble control word and the agreed ID/EX payload packing.
package pipe_pkg;

    localparam int DEFAULT_LEN_DATA = 32;
    localparam int DEFAULT_LEN_CTRL = 8;

    typedef logic [1:0] occ_t;

    // A bubble carries no control effects downstream.
    localparam logic [DEFAULT_LEN_CTRL-1:0] CTRL_BUBBLE = '0;

    // ID/EX payload packing, MSB first; every stage slices by these offsets.
    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_payload_t;

    localparam int IDEX_LEN         = $bits(idex_payload_t);
    localparam int IDEX_RD_LSB      = 0;
    localparam int IDEX_RS2_LSB     = 5;
    localparam int IDEX_RS1_LSB     = 10;
    localparam int IDEX_IMM_LSB     = 15;
    localparam int IDEX_RS2_VAL_LSB = 47;
    localparam int IDEX_RS1_VAL_LSB = 79;

    function automatic occ_t occ_count(input logic m_valid, input logic s_valid);
        return occ_t'({1'b0, m_valid}) + occ_t'({1'b0, s_valid});
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus payload/control register. Clearing always
// returns the entry to an all-zero bubble; clear wins over load.
module pipe_slot #(
    parameter int LEN_DATA = 32,
    parameter int LEN_CTRL = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                clear,
    input  logic [LEN_DATA-1:0] d_data,
    input  logic [LEN_CTRL-1:0] d_ctrl,
    output logic                valid,
    output logic [LEN_DATA-1:0] data,
    output logic [LEN_CTRL-1:0] ctrl
);

    logic                valid_reg;
    logic [LEN_DATA-1:0] data_reg;
    logic [LEN_CTRL-1:0] ctrl_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d_data;
            ctrl_reg  <= d_ctrl;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int LEN_DATA = DEFAULT_LEN_DATA,
    parameter int LEN_CTRL = DEFAULT_LEN_CTRL
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] in_data,
    input  logic [LEN_CTRL-1:0] in_ctrl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] out_data,
    output logic [LEN_CTRL-1:0] out_ctrl,
    output occ_t                occupancy
);

    logic                m_valid;
    logic [LEN_DATA-1:0] m_data;
    logic [LEN_CTRL-1:0] m_ctrl;
    logic                m_load;
    logic                m_clear;
    logic [LEN_DATA-1:0] m_d_data;
    logic [LEN_CTRL-1:0] m_d_ctrl;
    logic                in_xfer;
    logic                out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = m_valid && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic                s_valid;
    logic [LEN_DATA-1:0] s_data;
    logic [LEN_CTRL-1:0] s_ctrl;
    logic                s_load;
    logic                s_clear;

    // Depends only on slot state, so no out_ready -> in_ready path exists.
    assign in_ready = !s_valid;

    always_comb begin
        m_load   = 1'b0;
        m_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        m_d_data = in_data;
        m_d_ctrl = in_ctrl;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else if (s_valid && out_xfer) begin
            // in_ready is low here, so the skid beat is the only candidate.
            m_load   = 1'b1;
            m_d_data = s_data;
            m_d_ctrl = s_ctrl;
            s_clear  = 1'b1;
        end else if (in_xfer) begin
            if (!m_valid || out_xfer) begin
                m_load = 1'b1;
            end else begin
                s_load = 1'b1;
            end
        end else if (out_xfer) begin
            m_clear = 1'b1;
        end
    end

    pipe_slot #(
        .LEN_DATA (LEN_DATA),
        .LEN_CTRL (LEN_CTRL)
    ) u_slot_s (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (s_load),
        .clear   (s_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .valid   (s_valid),
        .data    (s_data),
        .ctrl    (s_ctrl)
    );

    assign occupancy = occ_count(m_valid, s_valid);
`else
    assign in_ready = !m_valid || out_ready;

    always_comb begin
        m_d_data = in_data;
        m_d_ctrl = in_ctrl;
        m_load   = in_xfer && !flush;
        m_clear  = flush || (out_xfer && !in_xfer);
    end

    assign occupancy = {1'b0, m_valid};
`endif

    pipe_slot #(
        .LEN_DATA (LEN_DATA),
        .LEN_CTRL (LEN_CTRL)
    ) u_slot_m (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (m_load),
        .clear   (m_clear),
        .d_data  (m_d_data),
        .d_ctrl  (m_d_ctrl),
        .valid   (m_valid),
        .data    (m_data),
        .ctrl    (m_ctrl)
    );

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_STAGE_REG_SKID_EN
// where skid and non-skid behaviour differ.
module tb_pipe_stage_reg;

    localparam int LD = 8;
    localparam int LC = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [LD-1:0] in_data;
    logic [LC-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [LD-1:0] out_data;
    logic [LC-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.LEN_DATA(LD), .LEN_CTRL(LC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          in_valid;
        logic [LD-1:0] in_data;
        logic [LC-1:0] in_ctrl;
        logic          out_ready;
        logic          exp_valid;
        logic [LD-1:0] exp_data;
        logic [LC-1:0] exp_ctrl;
        logic [1:0]    exp_occ;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [LD-1:0] d, input logic [LC-1:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [LD-1:0] d,
                           input logic [LC-1:0] c, input logic [1:0] o);
        chk({name, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({name, ".out_data"},  32'(out_data),  32'(d));
        chk({name, ".out_ctrl"},  32'(out_ctrl),  32'(c));
        chk({name, ".occupancy"}, 32'(occupancy), 32'(o));
    endtask

    // Stall sequence expectations, one entry per cycle with out_ready = 0,0,0,1,1.
    logic       stall_rdy   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] stall_out   [5] = '{8'h21, 8'h21, 8'h21, 8'h22, 8'h23};
`ifdef PIPE_STAGE_REG_SKID_EN
    logic       stall_inrdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] stall_occ   [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
`else
    logic       stall_inrdy [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] stall_occ   [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif

    initial begin
        logic [LD-1:0] next_beat;
        logic          acc;

        vecs[0] = '{in_valid:1'b1, in_data:8'h01, in_ctrl:4'h1, out_ready:1'b1,
                    exp_valid:1'b1, exp_data:8'h01, exp_ctrl:4'h1, exp_occ:2'd1};
        vecs[1] = '{in_valid:1'b1, in_data:8'h02, in_ctrl:4'h2, out_ready:1'b1,
                    exp_valid:1'b1, exp_data:8'h02, exp_ctrl:4'h2, exp_occ:2'd1};
        vecs[2] = '{in_valid:1'b1, in_data:8'h03, in_ctrl:4'h3, out_ready:1'b1,
                    exp_valid:1'b1, exp_data:8'h03, exp_ctrl:4'h3, exp_occ:2'd1};
        vecs[3] = '{in_valid:1'b1, in_data:8'h04, in_ctrl:4'h4, out_ready:1'b1,
                    exp_valid:1'b1, exp_data:8'h04, exp_ctrl:4'h4, exp_occ:2'd1};
        vecs[4] = '{in_valid:1'b0, in_data:8'h00, in_ctrl:4'h0, out_ready:1'b1,
                    exp_valid:1'b0, exp_data:8'h00, exp_ctrl:4'h0, exp_occ:2'd0};
        vecs[5] = '{in_valid:1'b1, in_data:8'h10, in_ctrl:4'h5, out_ready:1'b1,
                    exp_valid:1'b1, exp_data:8'h10, exp_ctrl:4'h5, exp_occ:2'd1};
        vecs[6] = '{in_valid:1'b0, in_data:8'h00, in_ctrl:4'h0, out_ready:1'b1,
                    exp_valid:1'b0, exp_data:8'h00, exp_ctrl:4'h0, exp_occ:2'd0};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        chk_out("reset", 1'b0, 8'h00, 4'h0, 2'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);
        $display("reset released: out_valid=%0b occ=%0d", out_valid, occupancy);

        // Streaming and drain vectors
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl, vecs[i].out_ready, 1'b0);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_ctrl, vecs[i].exp_occ);
            $display("vec %0d: in_valid=%0b in_data=%0h -> out_valid=%0b out_data=%0h occ=%0d",
                     i, vecs[i].in_valid, vecs[i].in_data, out_valid, out_data, occupancy);
        end

        // Stall for 3 cycles while upstream keeps offering beats
        drive(1'b1, 8'h21, 4'h1, 1'b1, 1'b0);
        tick();
        chk_out("stall.setup", 1'b1, 8'h21, 4'h1, 2'd1);
        next_beat = 8'h22;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, next_beat, 4'h1, stall_rdy[i], 1'b0);
            #1;
            chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'(stall_inrdy[i]));
            acc = in_valid && in_ready;
            tick();
            chk($sformatf("stall%0d.out_data", i), 32'(out_data), 32'(stall_out[i]));
            chk($sformatf("stall%0d.occupancy", i), 32'(occupancy), 32'(stall_occ[i]));
            $display("stall %0d: out_ready=%0b offered=%0h accepted=%0b -> out_data=%0h occ=%0d",
                     i, stall_rdy[i], next_beat, acc, out_data, occupancy);
            if (acc) next_beat = next_beat + 8'h01;
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk_out("stall.drain", 1'b0, 8'h00, 4'h0, 2'd0);

        // Flush kills held 0x55 and the offered 0xAA
        drive(1'b1, 8'h55, 4'h6, 1'b0, 1'b0);
        tick();
        chk_out("flush.load", 1'b1, 8'h55, 4'h6, 2'd1);
        drive(1'b1, 8'hAA, 4'h3, 1'b1, 1'b1);
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("flush.after", 1'b0, 8'h00, 4'h0, 2'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk_out("flush.idle", 1'b0, 8'h00, 4'h0, 2'd0);
        $display("flush: out_valid=%0b out_data=%0h", out_valid, out_data);

`ifdef PIPE_STAGE_REG_SKID_EN
        // Skid handoff: M=7, S=8, then release for two cycles
        drive(1'b1, 8'h07, 4'h7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h08, 4'h8, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk_out("skid.full", 1'b1, 8'h07, 4'h7, 2'd2);
        chk("skid.full.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk_out("skid.hand1", 1'b1, 8'h08, 4'h8, 2'd1);
        chk("skid.hand1.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("skid.hand2", 1'b0, 8'h00, 4'h0, 2'd0);
        $display("skid handoff: out_valid=%0b occ=%0d", out_valid, occupancy);

        // Flush with both entries full
        drive(1'b1, 8'h41, 4'h1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h42, 4'h2, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        chk_out("skid.flush", 1'b0, 8'h00, 4'h0, 2'd0);
        chk("skid.flush.in_ready", 32'(in_ready), 32'd1);
`else
        // Full M with downstream stalled refuses a second beat
        drive(1'b1, 8'h07, 4'h7, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h08, 4'h8, 1'b0, 1'b0);
        #1;
        chk("noskid.full.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_out("noskid.hold", 1'b1, 8'h07, 4'h7, 2'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk_out("noskid.drain", 1'b0, 8'h00, 4'h0, 2'd0);
        $display("no-skid hold: out_valid=%0b occ=%0d", out_valid, occupancy);
`endif

        // Asynchronous reset mid-stream, together with flush
        drive(1'b1, 8'h31, 4'h9, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h32, 4'hA, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 8'h00, 4'h0, 2'd0);
        chk("async_reset.in_ready", 32'(in_ready), 32'd1);
        tick();
        flush   = 1'b0;
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_out("post_reset.idle", 1'b0, 8'h00, 4'h0, 2'd0);
        $display("async reset: out_valid=%0b occ=%0d", out_valid, occupancy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic elastic pipeline register: the parametrised successor to the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width data payload plus a control-bit field between two pipeline stages. It adds a valid/ready handshake, a stall path, a flush that inserts a bubble, and an optional skid entry that registers the backward ready path. Every stage boundary of the next core revision is built from instances of this block.

## Interface
Parameters:
- LEN_DATA, 32: payload width (operands, immediate, register addresses packed by the instantiating stage).
- LEN_CTRL, 8: control-bit width (EX/M/WB controls); forced to zero whenever the stage holds a bubble.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries and of the current input beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  LEN_DATA  upstream payload.
- in_ctrl  in  LEN_CTRL  upstream control bits.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts (low = stall).
- out_data  out  LEN_DATA  registered payload.
- out_ctrl  out  LEN_CTRL  registered control bits.
- occupancy  out  2  entries held (0..1 without skid, 0..2 with skid).

## Operation
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Main slot M drives out_*. Skid slot S exists only with the skid macro.
- Bubble invariant: out_valid=0 implies out_data=0 and out_ctrl=0.
- No skid:
  - in_ready = !out_valid | out_ready (combinational).
  - An input transfer loads M.
  - An output transfer with no input transfer clears M to a bubble.
  - Neither: M holds (stall).
- With skid:
  - in_ready = !S.valid (registered, no combinational out_ready->in_ready path).
  - Input while M is empty, or M drains the same cycle: load M.
  - Input while M is full and not draining: load S.
  - M drains with S full: S moves to M, S clears; an input accepted that cycle is impossible (in_ready=0).
- Order is strictly FIFO; beats are never dropped or duplicated except by flush.
- flush has priority over every transfer:
  - Next cycle M and S are empty bubbles.
  - The input beat offered in the flush cycle is discarded, even if in_ready=1.
  - in_ready is not gated by flush.
- occupancy = M.valid + S.valid.

## Timing
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, S cleared. in_ready=1 during and after reset.
- Reset mid-operation discards all held beats immediately, without waiting for a clock edge.
- Latency: in->out is 1 cycle. Throughput: 1 beat/cycle with out_ready held high.
- Stall: out_ready low holds out_* stable. Downstream may sample out_* on any cycle.
- With skid: a single-cycle out_ready deassertion costs no upstream throughput, because S absorbs the in-flight beat.
- Simultaneous flush and reset_n low: reset wins. The result is identical.

## Configuration
- Macro PIPE_STAGE_REG_SKID_EN.
- Defined: S slot present; in_ready is registered; occupancy reaches 2.
- Undefined: S slot absent; in_ready is combinational; occupancy[1] is tied to 0.
- All other behaviour is identical under both settings.

## Structure
- Shared package pipe_pkg holds:
  - occupancy type (2-bit);
  - bubble constant (all-zero ctrl);
  - default LEN_DATA/LEN_CTRL constants;
  - the packing order of the ID/EX payload, so stages agree on field offsets.
- One sub-module, pipe_slot: a valid bit plus a payload register with load, clear-to-bubble, and async reset. M and S are two instances.

## Test plan
- Reset: hold reset_n low mid-stream with M and S full -> out_valid=0, out_ctrl=0, occupancy=0 before the next edge; in_ready=1.
- Streaming: drive in_data=1,2,3,4 back-to-back with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, each 1 cycle later; occupancy stays 1.
- Stall:
  - Drop out_ready for 3 cycles while streaming -> out_data holds stable.
  - No skid: in_ready=0 for those 3 cycles.
  - Skid: one extra beat is accepted, occupancy=2, then in_ready=0.
  - Order is preserved after release in both cases.
- Flush:
  - Assert flush with in_valid=1, in_data=0xAA and M holding 0x55 -> next cycle out_valid=0, out_data=0, out_ctrl=0.
  - Neither 0x55 nor 0xAA ever appears on out_data.
- Drain: with no input, out_ready=1 and M=0x10 valid -> next cycle out_valid=0, out_ctrl=0 (bubble invariant).
- Skid handoff (skid only): fill M=7, S=8, then raise out_ready for 2 cycles -> out_data 7 then 8; in_ready rises the cycle after S empties.
